// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: M-stage load/store to req/ready + rvalid data bus.
// Optional bus timeout: define DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MemRead_M,
  input  logic              MemWrite_M,
  input  logic [31:0]       ALUResult_M,
  input  logic [31:0]       WriteData_M,
  output logic [31:0]       ReadData_M,
  output logic              MemStall_M,
  output logic              AddrErr_M,
  output logic              BusErr_M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic              access;
  logic              aligned;
  logic              latch;
  logic              ld_rdata;
  logic              clr_rd;
  logic              time_out;
  logic              expire;

  logic [ADDR_W-3:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [31:0]       rd_q;

  assign access  = MemRead_M | MemWrite_M;
  assign aligned = (ALUResult_M[1:0] == 2'b00);

`ifdef DMEM_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        bus_err_q;

  assign expire   = (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign BusErr_M = bus_err_q;

  // Wait counter: restarts with each issued access, counts REQ/WAIT cycles.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= time_out;
      if (latch) begin
        wait_cnt <= '0;
      end else if (state == REQ || state == WAIT) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end
`else
  assign expire   = 1'b0 && (TIMEOUT_CYCLES > 0);
  assign BusErr_M = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, stall/request outputs and datapath load strobes.
  always_comb begin
    state_nx   = state;
    mem_req    = 1'b0;
    MemStall_M = 1'b0;
    AddrErr_M  = 1'b0;
    latch      = 1'b0;
    ld_rdata   = 1'b0;
    clr_rd     = 1'b0;
    time_out   = 1'b0;
    unique case (state)
      IDLE: begin
        if (RST && access) begin
          if (aligned) begin
            MemStall_M = 1'b1;
            latch      = 1'b1;
            state_nx   = REQ;
          end else begin
            AddrErr_M = 1'b1;
            clr_rd    = 1'b1;
          end
        end
      end
      REQ: begin
        mem_req    = 1'b1;
        MemStall_M = 1'b1;
        if (mem_ready) begin
          if (we_q) begin
            clr_rd   = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = WAIT;
          end
        end else if (expire) begin
          time_out = 1'b1;
          state_nx = DONE;
        end
      end
      WAIT: begin
        MemStall_M = 1'b1;
        if (mem_rvalid) begin
          ld_rdata = 1'b1;
          state_nx = DONE;
        end else if (expire) begin
          time_out = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Request latch and load-data register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      if (latch) begin
        addr_q  <= (ADDR_W-2)'(ALUResult_M[31:2]);
        wdata_q <= WriteData_M;
        we_q    <= MemWrite_M;
      end
      if (ld_rdata) begin
        rd_q <= mem_rdata;
      end else if (clr_rd) begin
        rd_q <= '0;
      end else if (time_out) begin
        rd_q <= 32'hDEADBEEF;
      end
    end
  end

  assign mem_we     = (state == REQ) & we_q;
  assign mem_addr   = {addr_q, 2'b00};
  assign mem_wdata  = wdata_q;
  assign ReadData_M = AddrErr_M ? 32'h0 : rd_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed steps with a bus-transaction scoreboard.
// Optional timeout step when DMEM_TIMEOUT_EN is defined.
module tb_dmem_access_ctrl;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MemRead_M;
  logic        MemWrite_M;
  logic [31:0] ALUResult_M;
  logic [31:0] WriteData_M;
  logic [31:0] ReadData_M;
  logic        MemStall_M;
  logic        AddrErr_M;
  logic        BusErr_M;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;
  int bus_txn = 0;
  int rdy_dly = 0;
  int req_cyc = 0;
  bit pend = 0;
  bit auto_bus = 1;
  logic [31:0] rd_val = '0;
  txn_t exp_q[$];

  dmem_access_ctrl #(
    .ADDR_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .MemRead_M(MemRead_M),
    .MemWrite_M(MemWrite_M),
    .ALUResult_M(ALUResult_M),
    .WriteData_M(WriteData_M),
    .ReadData_M(ReadData_M),
    .MemStall_M(MemStall_M),
    .AddrErr_M(AddrErr_M),
    .BusErr_M(BusErr_M),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Bus model: ready after rdy_dly REQ cycles, rvalid on first WAIT cycle.
  always @(posedge CLK) begin
    #1;
    if (auto_bus) begin
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      if (mem_req) begin
        if (req_cyc == rdy_dly) begin
          mem_ready = 1'b1;
          req_cyc   = 0;
          pend      = !mem_we;
        end else begin
          req_cyc++;
        end
      end else if (pend) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_val;
        pend       = 1'b0;
      end
    end else begin
      req_cyc = 0;
      pend    = 1'b0;
    end
  end

  // Scoreboard: every accepted request must match the next expected one.
  always @(negedge CLK) begin
    if (RST === 1'b1 && mem_req === 1'b1 && mem_ready === 1'b1) begin
      bus_txn++;
      if (exp_q.size() == 0) begin
        chk("bus_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        txn_t e;
        e = exp_q.pop_front();
        chk("bus_we", 32'(mem_we), 32'(e.we));
        chk("bus_addr", mem_addr, e.addr);
        if (e.we) chk("bus_wdata", mem_wdata, e.wdata);
      end
    end
  end

  task automatic run_access(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int dly,
                            input logic [31:0] rdata, input int exp_stall,
                            input int exp_req);
    int stalls = 0;
    int reqs = 0;
    bit done = 0;
    txn_t t;
    @(posedge CLK);
    #1;
    rdy_dly     = dly;
    rd_val      = rdata;
    MemRead_M   = !we;
    MemWrite_M  = we;
    ALUResult_M = addr;
    WriteData_M = wdata;
    t.we = we;
    t.addr = addr;
    t.wdata = wdata;
    exp_q.push_back(t);
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge CLK);
      if (MemStall_M === 1'b1) begin
        stalls++;
        if (mem_req === 1'b1) begin
          reqs++;
          chk("req_addr", mem_addr, addr);
          chk("req_we", 32'(mem_we), 32'(we));
          if (we) chk("req_wdata", mem_wdata, wdata);
        end
      end else begin
        done = 1;
      end
    end
    chk("done_reached", 32'(done), 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    chk("req_cycles", 32'(reqs), 32'(exp_req));
    chk("done_rdata", ReadData_M, we ? 32'h0 : rdata);
    chk("done_no_req", 32'(mem_req), 32'd0);
  endtask

  task automatic idle_m();
    @(posedge CLK);
    #1;
    MemRead_M  = 1'b0;
    MemWrite_M = 1'b0;
  endtask

  initial begin
    RST         = 1'b0;
    MemRead_M   = 1'b0;
    MemWrite_M  = 1'b0;
    ALUResult_M = '0;
    WriteData_M = '0;
    mem_ready   = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_stall", 32'(MemStall_M), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addrerr", 32'(AddrErr_M), 32'd0);
    chk("rst_buserr", 32'(BusErr_M), 32'd0);
    chk("rst_rdata", ReadData_M, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b1;

    run_access(1'b0, 32'h10, 32'h0, 0, 32'hCAFEF00D, 3, 1);

    @(posedge CLK);
    #1;
    MemRead_M   = 1'b1;
    MemWrite_M  = 1'b0;
    ALUResult_M = 32'h13;
    @(negedge CLK);
    chk("mis_addrerr", 32'(AddrErr_M), 32'd1);
    chk("mis_stall", 32'(MemStall_M), 32'd0);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_rdata", ReadData_M, 32'h0);
    idle_m();
    @(negedge CLK);
    chk("mis_pulse_end", 32'(AddrErr_M), 32'd0);
    chk("mis_rdata_hold", ReadData_M, 32'h0);
    chk("mis_req_after", 32'(mem_req), 32'd0);

    run_access(1'b1, 32'h24, 32'h12345678, 4, 32'h0, 6, 5);
    idle_m();

    run_access(1'b0, 32'h40, 32'h0, 0, 32'h0BADC0DE, 3, 1);
    run_access(1'b1, 32'h44, 32'hA5A5_5A5A, 0, 32'h0, 2, 1);
    idle_m();
    @(negedge CLK);
    chk("b2b_idle_req", 32'(mem_req), 32'd0);
    chk("b2b_count", 32'(bus_txn), 32'd4);

    run_access(1'b0, 32'h50, 32'h0, 2, 32'h5555AAAA, 5, 3);
    idle_m();

    @(posedge CLK);
    #1;
    auto_bus    = 1'b0;
    mem_ready   = 1'b0;
    mem_rvalid  = 1'b0;
    MemRead_M   = 1'b1;
    ALUResult_M = 32'h80;
    exp_q.push_back('{1'b0, 32'h80, 32'h0});
    @(posedge CLK);
    #1;
    mem_ready = 1'b1;
    @(posedge CLK);
    #1;
    mem_ready = 1'b0;
    MemRead_M = 1'b0;
    RST       = 1'b0;
    @(negedge CLK);
    chk("wait_stall", 32'(MemStall_M), 32'd1);
    @(posedge CLK);
    #1;
    RST        = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("late_stall", 32'(MemStall_M), 32'd0);
      chk("late_req", 32'(mem_req), 32'd0);
      chk("late_rdata", ReadData_M, 32'h0);
      @(posedge CLK);
      #1;
    end
    mem_rvalid = 1'b0;
    auto_bus   = 1'b1;

    run_access(1'b0, 32'h60, 32'h0, 1, 32'h600DF00D, 4, 2);
    idle_m();

`ifdef DMEM_TIMEOUT_EN
    begin
      int stalls = 0;
      bit done = 0;
      @(posedge CLK);
      #1;
      auto_bus    = 1'b0;
      mem_ready   = 1'b0;
      MemRead_M   = 1'b1;
      ALUResult_M = 32'h90;
      for (int i = 0; i < 64 && !done; i++) begin
        @(negedge CLK);
        if (MemStall_M === 1'b1) stalls++;
        else done = 1;
      end
      chk("to_done", 32'(done), 32'd1);
      chk("to_stalls", 32'(stalls), 32'd9);
      chk("to_buserr", 32'(BusErr_M), 32'd1);
      chk("to_rdata", ReadData_M, 32'hDEADBEEF);
      chk("to_req", 32'(mem_req), 32'd0);
      idle_m();
      @(negedge CLK);
      chk("to_pulse_end", 32'(BusErr_M), 32'd0);
      auto_bus = 1'b1;
    end
`else
    @(negedge CLK);
    chk("buserr_off", 32'(BusErr_M), 32'd0);
`endif

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("bus_total", 32'(bus_txn), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
